mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-stage load/store unit that consumes the EX/MEM pipeline register outputs and drives the data-memory request/response interface. It generates the memory-stage stall that freezes the EX/MEM register while an access is outstanding. It aligns store data and byte enables and sign- or zero-extends load data per func3. It optionally traps misaligned accesses.

## Interface
- DATA_WIDTH, 64, data width; fixed at 64 (8 byte lanes).
- ADDR_WIDTH, 64, address width.
- i_clk  in  1  clock.
- i_arst  in  1  asynchronous active-high reset.
- i_mem_access  in  1  current MEM-stage instruction is a load or store.
- i_mem_we  in  1  1 = store, 0 = load.
- i_func3  in  3  access size and sign, RISC-V encoding.
- i_addr  in  ADDR_WIDTH  byte address (ALU result).
- i_write_data  in  DATA_WIDTH  store data, right-justified.
- o_req_valid  out  1  request valid.
- i_req_ready  in  1  memory accepts request.
- o_req_we  out  1  request is a write.
- o_req_addr  out  ADDR_WIDTH  i_addr with bits [2:0] cleared.
- o_req_wdata  out  DATA_WIDTH  lane-shifted store data.
- o_req_be  out  8  byte enables.
- i_resp_valid  in  1  response/ack valid, one cycle.
- i_resp_rdata  in  DATA_WIDTH  read data, 8-byte aligned word.
- o_stall_mem  out  1  stall to the EX/MEM register and upstream.
- o_load_data  out  DATA_WIDTH  extended load result (registered).
- o_misaligned  out  1  misaligned access detected.
- o_cause  out  4  exception cause: 4 load misaligned, 6 store misaligned, else 0.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. One outstanding request at most.
- IDLE:
  - o_req_valid = i_mem_access & ~o_misaligned.
  - If the request is valid and i_req_ready is high, go to WAIT. If valid and not ready, go to REQ.
- REQ: hold o_req_valid high; go to WAIT on i_req_ready.
- WAIT:
  - On i_resp_valid, register the extended load into o_load_data (loads only) and go to DONE.
  - Store responses are acks; o_load_data is unchanged.
- DONE: return to IDLE unconditionally.
- o_stall_mem = (IDLE & o_req_valid) | REQ | WAIT. It is low in DONE, so the pipeline advances exactly once per access.
- Request fields are combinational from the inputs. The inputs are stable while stalled because the EX/MEM register holds.
- Byte offset is off = i_addr[2:0].
- Store alignment:
  - o_req_wdata = i_write_data << 8*off.
  - o_req_be: SB 8'h01<<off, SH 8'h03<<off, SW 8'h0F<<off, SD 8'hFF.
  - Loads drive o_req_be = 8'hFF.
- Load extraction: take (i_resp_rdata >> 8*off) and extend as follows:
  - 000 LB: sign-extend from bit 7.
  - 001 LH: sign-extend from bit 15.
  - 010 LW: sign-extend from bit 31.
  - 011 LD: no extension.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 111: treated as LD.
- When i_mem_access is low: no request, no stall, o_cause = 0.

## Timing
- Reset values:
  - State is IDLE.
  - o_load_data = 0.
  - With no access present after reset, all combinational outputs evaluate to 0 (valid, stall, we, be, misaligned, cause).
- Minimum access latency is 3 cycles:
  - Cycle 0: request accepted.
  - Cycle 1: response.
  - Cycle 2: DONE, stall low.
  - The EX/MEM register advances at the end of cycle 2.
- Each cycle of i_req_ready low or response delay adds one cycle.
- i_resp_valid is ignored outside WAIT, including during the acceptance cycle.
- o_load_data is valid from DONE and held until the next load response.
- Reset mid-access abandons the request and forces IDLE. The memory side shares i_arst and must also reset.
- A misaligned access produces no request and no stall. o_misaligned and o_cause are valid in the same cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned access asserts o_misaligned.
  - Misaligned means a halfword with off[0] set, a word with off[1:0] nonzero, or a doubleword with off nonzero.
  - o_cause is 4 for a load and 6 for a store.
  - No request is issued.
- Undefined:
  - o_misaligned and o_cause are tied to 0.
  - Misaligned accesses are issued, with the enable/shift computed as above and bytes beyond lane 7 dropped.

## Test plan
- LW at addr 0x1004, ready immediate, response 0x80000001_00000000 at cycle 1 -> o_load_data = 0xFFFFFFFF_80000001 in cycle 2; stall high for cycles 0-1 only.
- LBU at addr 0x1003, rdata 0x00000000_FF000000 -> o_load_data = 0x00000000_000000FF.
- SH at addr 0x2002, write_data 0xABCD, i_req_ready low for 3 cycles -> o_req_be = 8'h0C and o_req_wdata = 0x00000000_ABCD0000, held stable; stall lasts 5 cycles.
- LD at addr 0x3004 with MISALIGN_TRAP_EN -> o_misaligned = 1, o_cause = 4, o_req_valid = 0, o_stall_mem = 0.
- i_arst pulsed during WAIT -> next cycle state IDLE, o_load_data = 0, o_stall_mem = 0; a late i_resp_valid is ignored.
- Back-to-back SD then LD to 0x4000 -> two distinct requests, one DONE cycle between them, and the LD returns the stored data.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: aligns stores, extends loads, stalls EX/MEM while an access is outstanding.
// Latency: 3 cycles minimum (accept, response, DONE); each cycle of ready-low or response delay adds one.
// Backpressure: o_stall_mem holds the EX/MEM register through REQ/WAIT; MISALIGN_TRAP_EN enables the misalignment trap.
module mem_stage_lsu #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_mem_access,
  input  logic                  i_mem_we,
  input  logic [2:0]            i_func3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic                  o_req_valid,
  input  logic                  i_req_ready,
  output logic                  o_req_we,
  output logic [ADDR_WIDTH-1:0] o_req_addr,
  output logic [DATA_WIDTH-1:0] o_req_wdata,
  output logic [7:0]            o_req_be,
  input  logic                  i_resp_valid,
  input  logic [DATA_WIDTH-1:0] i_resp_rdata,
  output logic                  o_stall_mem,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_misaligned,
  output logic [3:0]            o_cause
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [2:0]            off;
  logic [1:0]            size;
  logic                  misaligned_hit;
  logic                  issue;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  assign off  = i_addr[2:0];
  assign size = i_func3[1:0];

`ifdef MISALIGN_TRAP_EN
  logic mis_raw;
  always_comb begin
    mis_raw = 1'b0;
    case (size)
      2'b00:   mis_raw = 1'b0;
      2'b01:   mis_raw = off[0];
      2'b10:   mis_raw = |off[1:0];
      default: mis_raw = |off;
    endcase
  end
  assign misaligned_hit = i_mem_access & mis_raw;
`else
  assign misaligned_hit = 1'b0;
`endif

  assign o_misaligned = misaligned_hit;
  assign o_cause      = misaligned_hit ? (i_mem_we ? 4'd6 : 4'd4) : 4'd0;
  assign issue        = i_mem_access & ~misaligned_hit;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (issue) state_nxt = i_req_ready ? WAIT : REQ;
      REQ:  if (i_req_ready) state_nxt = WAIT;
      WAIT: if (i_resp_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_req_valid = 1'b0;
    o_stall_mem = 1'b0;
    case (state)
      IDLE: begin
        o_req_valid = issue;
        o_stall_mem = issue;
      end
      REQ: begin
        o_req_valid = 1'b1;
        o_stall_mem = 1'b1;
      end
      WAIT:    o_stall_mem = 1'b1;
      default: ;
    endcase
  end

  // Request fields follow the EX/MEM outputs directly; they stay stable because that register is stalled.
  assign o_req_we    = i_mem_access & i_mem_we;
  assign o_req_addr  = {i_addr[ADDR_WIDTH-1:3], 3'b000};
  assign o_req_wdata = i_write_data << {off, 3'b000};

  always_comb begin
    o_req_be = 8'h00;
    if (i_mem_access) begin
      if (!i_mem_we) o_req_be = 8'hFF;
      else begin
        case (size)
          2'b00:   o_req_be = 8'h01 << off;
          2'b01:   o_req_be = 8'h03 << off;
          2'b10:   o_req_be = 8'h0F << off;
          default: o_req_be = 8'hFF;
        endcase
      end
    end
  end

  assign shifted = i_resp_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (i_func3)
      3'b000:  load_ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      3'b110:  load_ext = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) o_load_data <= '0;
    else if (state == WAIT && i_resp_valid && !i_mem_we) o_load_data <= load_ext;
  end

endmodule
